inst_decode_stage: RTL and testbench
====================================

// Module: inst_decode_stage
// PURPOSE
//  Registered decode stage for the 9-bit ISA. Consumes raw instruction words
//  from fetch and produces decoded control/operand fields for execute.
//  Buffers one instruction with a valid/ready handshake on both sides, tracks
//  halt, and counts illegal encodings.
//  Opcode/funct values are the shared ISA definitions: Opcode enum, FUN_* constants,
//  InstType {I,M,B,R}.
// PARAMETERS
//  PC_W     8   width of program counter carried alongside instruction
//  ILL_CW   4   width of saturating illegal-instruction counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      reset; asynchronous, active-low
//  in_valid     in   1      fetch presents in_inst/in_pc
//  in_ready     out  1      stage can accept this cycle
//  in_inst      in   9      raw instruction word
//  in_pc        in   PC_W   PC of in_inst
//  flush        in   1      discard held instruction (branch redirect)
//  resume       in   1      leave HALTED state
//  out_valid    out  1      decoded instruction available
//  out_ready    in   1      execute consumes this cycle
//  out_pc       out  PC_W   PC of held instruction
//  out_type     out  2      InstType of held instruction
//  out_opcode   out  3      inst[8:6]
//  out_funct    out  2      inst[5:4] (R/B types), else 0
//  out_rd       out  3      destination / first register field
//  out_rs       out  3      source register field
//  out_imm      out  8      extended immediate
//  out_reg_we   out  1      instruction writes a register
//  out_mem_rd   out  1      load
//  out_mem_wr   out  1      store
//  out_branch   out  1      conditional branch
//  out_halt     out  1      held instruction is HALT (R_NEG, FUN_HALT)
//  out_illegal  out  1      held instruction is an undefined encoding
//  halted       out  1      FSM in HALTED
//  ill_count    out  ILL_CW saturating count of illegal instructions accepted
// BEHAVIOUR
//  Reset (async, rst_n=0): all out_* = 0, out_valid=0, halted=0, ill_count=0, FSM=RUN.
//  Field decode (combinational on in_inst, registered on accept):
//   R: funct=[5:4], rd={0,[3:2]}, rs={0,[1:0]}, imm=0, reg_we=1 except HALT.
//   I: LW/SW rd={0,[5:4]}, imm=zero-ext [3:0]; SET rd=0, imm=zero-ext [5:0].
//      LW mem_rd=1, reg_we=1; SW mem_wr=1, reg_we=0; SET reg_we=1.
//   B: funct=[5:4] (BEQ/BNE/BGT/BLT), imm=sign-ext [3:0], branch=1, reg_we=0.
//   M: MOV rd=[5:3], rs=[2:0], reg_we=1.
//   Illegal: R_SHF with funct=3 -> illegal=1, reg_we=mem_*=branch=0.
//  Handshake: one-entry pipeline register. accept = in_valid & in_ready.
//   in_ready = (~out_valid | out_ready) & (FSM==RUN).
//   Latency 1: instruction accepted in cycle N is on out_* with out_valid=1 in N+1.
//   Output fields stable while out_valid & ~out_ready.
//   Simultaneous consume+accept: new word replaces held word, out_valid stays 1.
//  flush: highest priority. Next cycle out_valid=0; word offered in the flush cycle
//   is not accepted (in_ready forced 0 that cycle). In HALT_PEND, flush returns FSM to RUN.
//   flush does not leave HALTED.
//  FSM:
//   RUN -> HALT_PEND on accept of HALT.
//   HALT_PEND -> HALTED when HALT consumed (out_valid & out_ready).
//   HALT_PEND -> RUN on flush.
//   HALTED -> RUN on resume.
//   halted=1 only in HALTED.
//  ill_count: +1 per accepted illegal word; saturates at 2^ILL_CW-1.
//  Reset mid-operation: held word dropped, no handshake completes that cycle.
// TESTING
//  1 MOV r5,r2 (9'b<MOV>101010) with out_ready=1 -> next cycle out_valid=1, rd=5, rs=2, reg_we=1.
//  2 BEQ offset 4'b1110 -> imm=8'hFE, branch=1; hold out_ready=0 3 cycles -> fields stable, in_ready=0.
//  3 HALT accepted -> halt=1; consume -> halted=1, in_ready=0 despite in_valid; resume -> in_ready=1.
//  4 flush in same cycle as in_valid with held word -> out_valid=0 next cycle, offered word dropped.
//  5 Stream 20 illegal R_SHF funct=3 with ILL_CW=4 -> ill_count stops at 15, reg_we=0 each.
//  6 Back-to-back 8 words, out_ready=1 -> one output per cycle, no bubbles; rst_n low mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/inst_decode_stage.sv
// Registered decode stage for the 9-bit ISA: one-entry valid/ready buffer between
// fetch and execute, with halt tracking and a saturating illegal-encoding counter.

package inst_decode_pkg;

    typedef enum logic [1:0] {
        IT_I = 2'd0,
        IT_M = 2'd1,
        IT_B = 2'd2,
        IT_R = 2'd3
    } inst_type_e;

    typedef enum logic [2:0] {
        OP_LW    = 3'd0,
        OP_SW    = 3'd1,
        OP_SET   = 3'd2,
        OP_MOV   = 3'd3,
        OP_BR    = 3'd4,
        OP_R_ALU = 3'd5,
        OP_R_SHF = 3'd6,
        OP_R_NEG = 3'd7
    } opcode_e;

    localparam logic [1:0] FUN_SHF_RSVD = 2'd3;
    localparam logic [1:0] FUN_HALT     = 2'd3;

    typedef struct packed {
        inst_type_e itype;
        logic [2:0] opcode;
        logic [1:0] funct;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       halt;
        logic       illegal;
    } dec_t;

endpackage

module inst_decode_stage
    import inst_decode_pkg::*;
#(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned ILL_CW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              resume,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        out_type,
    output logic [2:0]        out_opcode,
    output logic [1:0]        out_funct,
    output logic [2:0]        out_rd,
    output logic [2:0]        out_rs,
    output logic [7:0]        out_imm,
    output logic              out_reg_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_branch,
    output logic              out_halt,
    output logic              out_illegal,
    output logic              halted,
    output logic [ILL_CW-1:0] ill_count
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2
    } state_e;

    state_e             state_q;
    logic               out_valid_q;
    dec_t               dec_q;
    dec_t               dec_d;
    logic [PC_W-1:0]    pc_q;
    logic [ILL_CW-1:0]  ill_count_q;
    logic               accept;

    // Field decode of the word currently offered by fetch
    always_comb begin
        dec_d        = '0;
        dec_d.opcode = in_inst[8:6];
        case (opcode_e'(in_inst[8:6]))
            OP_LW: begin
                dec_d.itype  = IT_I;
                dec_d.rd     = {1'b0, in_inst[5:4]};
                dec_d.imm    = {4'b0000, in_inst[3:0]};
                dec_d.mem_rd = 1'b1;
                dec_d.reg_we = 1'b1;
            end
            OP_SW: begin
                dec_d.itype  = IT_I;
                dec_d.rd     = {1'b0, in_inst[5:4]};
                dec_d.imm    = {4'b0000, in_inst[3:0]};
                dec_d.mem_wr = 1'b1;
            end
            OP_SET: begin
                dec_d.itype  = IT_I;
                dec_d.imm    = {2'b00, in_inst[5:0]};
                dec_d.reg_we = 1'b1;
            end
            OP_MOV: begin
                dec_d.itype  = IT_M;
                dec_d.rd     = in_inst[5:3];
                dec_d.rs     = in_inst[2:0];
                dec_d.reg_we = 1'b1;
            end
            OP_BR: begin
                dec_d.itype  = IT_B;
                dec_d.funct  = in_inst[5:4];
                dec_d.imm    = {{4{in_inst[3]}}, in_inst[3:0]};
                dec_d.branch = 1'b1;
            end
            default: begin
                dec_d.itype = IT_R;
                dec_d.funct = in_inst[5:4];
                dec_d.rd    = {1'b0, in_inst[3:2]};
                dec_d.rs    = {1'b0, in_inst[1:0]};
                if (in_inst[8:6] == OP_R_SHF && in_inst[5:4] == FUN_SHF_RSVD) begin
                    dec_d.illegal = 1'b1;
                end else if (in_inst[8:6] == OP_R_NEG && in_inst[5:4] == FUN_HALT) begin
                    dec_d.halt = 1'b1;
                end else begin
                    dec_d.reg_we = 1'b1;
                end
            end
        endcase
    end

    // A flush cycle never accepts; only RUN accepts new words
    assign in_ready = (~out_valid_q | out_ready) & (state_q == ST_RUN) & ~flush;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            pc_q        <= '0;
            ill_count_q <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                dec_q       <= dec_d;
                pc_q        <= in_pc;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept && dec_d.illegal && (ill_count_q != {ILL_CW{1'b1}})) begin
                ill_count_q <= ill_count_q + ILL_CW'(1);
            end

            case (state_q)
                ST_RUN: begin
                    if (accept && dec_d.halt) state_q <= ST_HALT_PEND;
                end
                ST_HALT_PEND: begin
                    if (flush)                          state_q <= ST_RUN;
                    else if (out_valid_q && out_ready)  state_q <= ST_HALTED;
                end
                ST_HALTED: begin
                    if (resume) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = pc_q;
    assign out_type    = dec_q.itype;
    assign out_opcode  = dec_q.opcode;
    assign out_funct   = dec_q.funct;
    assign out_rd      = dec_q.rd;
    assign out_rs      = dec_q.rs;
    assign out_imm     = dec_q.imm;
    assign out_reg_we  = dec_q.reg_we;
    assign out_mem_rd  = dec_q.mem_rd;
    assign out_mem_wr  = dec_q.mem_wr;
    assign out_branch  = dec_q.branch;
    assign out_halt    = dec_q.halt;
    assign out_illegal = dec_q.illegal;
    assign halted      = (state_q == ST_HALTED);
    assign ill_count   = ill_count_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the decode stage.

module tb_inst_decode_stage;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned ILL_CW = 4;
    localparam int          CNT_MAX = (1 << ILL_CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [8:0]        in_inst = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              flush = 1'b0;
    logic              resume = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PC_W-1:0]   out_pc;
    logic [1:0]        out_type;
    logic [2:0]        out_opcode;
    logic [1:0]        out_funct;
    logic [2:0]        out_rd;
    logic [2:0]        out_rs;
    logic [7:0]        out_imm;
    logic              out_reg_we;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              out_branch;
    logic              out_halt;
    logic              out_illegal;
    logic              halted;
    logic [ILL_CW-1:0] ill_count;

    inst_decode_stage #(.PC_W(PC_W), .ILL_CW(ILL_CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_type(out_type), .out_opcode(out_opcode), .out_funct(out_funct),
        .out_rd(out_rd), .out_rs(out_rs), .out_imm(out_imm),
        .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_branch(out_branch), .out_halt(out_halt), .out_illegal(out_illegal),
        .halted(halted), .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic [1:0] typ;
        logic [2:0] opcode;
        logic [1:0] funct;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [7:0] imm;
        logic       we;
        logic       mrd;
        logic       mwr;
        logic       br;
        logic       halt;
        logic       ill;
    } exp_t;

    // Model state: held word, mode (0 run, 1 halt pending, 2 halted), illegal count
    exp_t m_out;
    bit   m_valid;
    int   m_mode;
    int   m_cnt;
    int   checks = 0;
    int   errors = 0;

    // Opcodes: 0 LW, 1 SW, 2 SET, 3 MOV, 4 branch, 5 R-alu, 6 R-shift, 7 R-neg
    // Types: 0 I, 1 M, 2 B, 3 R
    function automatic exp_t ref_decode(input logic [8:0] w, input logic [7:0] pc);
        exp_t e;
        int op, f, off;
        e = '0;
        op = int'(w) / 64;
        f  = (int'(w) / 16) % 4;
        e.pc = pc;
        e.opcode = 3'(op);
        if (op <= 2) begin
            e.typ = 2'd0;
            if (op == 2) begin
                e.imm = 8'(int'(w) % 64);
                e.we  = 1'b1;
            end else begin
                e.rd  = 3'(f);
                e.imm = 8'(int'(w) % 16);
                e.we  = (op == 0);
                e.mrd = (op == 0);
                e.mwr = (op == 1);
            end
        end else if (op == 3) begin
            e.typ = 2'd1;
            e.rd  = 3'((int'(w) / 8) % 8);
            e.rs  = 3'(int'(w) % 8);
            e.we  = 1'b1;
        end else if (op == 4) begin
            e.typ   = 2'd2;
            e.funct = 2'(f);
            off = int'(w) % 16;
            if (off >= 8) off = off - 16;
            e.imm = off[7:0];
            e.br  = 1'b1;
        end else begin
            e.typ   = 2'd3;
            e.funct = 2'(f);
            e.rd    = 3'((int'(w) / 4) % 4);
            e.rs    = 3'(int'(w) % 4);
            if (op == 6 && f == 3)      e.ill  = 1'b1;
            else if (op == 7 && f == 3) e.halt = 1'b1;
            else                        e.we   = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t e;
        e = {out_pc, out_type, out_opcode, out_funct, out_rd, out_rs, out_imm,
             out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_halt, out_illegal};
        return e;
    endfunction

    function automatic bit exp_ready();
        return (!m_valid || out_ready) && (m_mode == 0) && !flush;
    endfunction

    task automatic drive(input bit v, input logic [8:0] w, input logic [7:0] pc,
                         input bit ordy, input bit fl, input bit res);
        in_valid  = v;
        in_inst   = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        resume    = res;
    endtask

    // Advance one clock and update the model from the current inputs
    task automatic tick();
        exp_t nx;
        bit acc;
        acc = in_valid && exp_ready();
        nx  = ref_decode(in_inst, in_pc);
        case (m_mode)
            0: if (acc && nx.halt) m_mode = 1;
            1: if (flush) m_mode = 0; else if (m_valid && out_ready) m_mode = 2;
            default: if (resume) m_mode = 0;
        endcase
        if (acc && nx.ill && m_cnt < CNT_MAX) m_cnt++;
        if (flush) m_valid = 0;
        else if (acc) begin m_valid = 1; m_out = nx; end
        else if (out_ready) m_valid = 0;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_out = '0; m_valid = 0; m_mode = 0; m_cnt = 0;
    endfunction

    task automatic test_reset();
        model_reset();
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (dut_out() !== exp_t'(0)) begin errors++; $display("FAIL reset_fields: got %h want 0", dut_out()); end
        checks++; if (halted !== 1'b0 || ill_count !== '0) begin errors++; $display("FAIL reset_status: halted %b cnt %0d want 0 0", halted, ill_count); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_mov();
        drive(1, 9'b011_101_010, 8'h10, 1, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mov_in_ready: got %b want 1", in_ready); end
        tick();
        drive(0, '0, '0, 1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mov_valid: got %b want 1", out_valid); end
        checks++; if (out_rd !== 3'd5 || out_rs !== 3'd2 || out_reg_we !== 1'b1 || out_type !== 2'd1)
            begin errors++; $display("FAIL mov_fields: rd %0d rs %0d we %b type %0d want 5 2 1 1", out_rd, out_rs, out_reg_we, out_type); end
        checks++; if (dut_out() !== m_out) begin errors++; $display("FAIL mov_model: got %h want %h", dut_out(), m_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mov_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_branch_stall();
        exp_t snap;
        drive(1, 9'b100_00_1110, 8'h21, 0, 0, 0);
        tick();
        snap = dut_out();
        checks++; if (out_imm !== 8'hFE || out_branch !== 1'b1 || out_reg_we !== 1'b0)
            begin errors++; $display("FAIL br_fields: imm %h br %b we %b want fe 1 0", out_imm, out_branch, out_reg_we); end
        checks++; if (snap !== m_out) begin errors++; $display("FAIL br_model: got %h want %h", snap, m_out); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 9'(9'h0AB + i), 8'(8'h30 + i), 0, 0, 0);
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL br_stall_ready%0d: got %b want 0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || dut_out() !== m_out)
                begin errors++; $display("FAIL br_stable%0d: got %b %h want 1 %h", i, out_valid, dut_out(), m_out); end
        end
        drive(0, '0, '0, 1, 0, 0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL br_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_halt();
        drive(1, 9'b111_11_0000, 8'h40, 0, 0, 0);
        tick();
        checks++; if (out_halt !== 1'b1 || out_reg_we !== 1'b0 || halted !== 1'b0)
            begin errors++; $display("FAIL halt_held: halt %b we %b halted %b want 1 0 0", out_halt, out_reg_we, halted); end
        drive(1, 9'h0C5, 8'h41, 1, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_pend_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL halt_enter: halted %b valid %b want 1 0", halted, out_valid); end
        drive(1, 9'h0C5, 8'h42, 1, 1, 0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halted_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_flush: got %b want 1", halted); end
        drive(0, '0, '0, 1, 0, 1);
        tick();
        drive(1, 9'h0C5, 8'h43, 1, 0, 0);
        #1;
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL resume: halted %b ready %b want 0 1", halted, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 8'h43)
            begin errors++; $display("FAIL resume_accept: valid %b pc %h want 1 43", out_valid, out_pc); end
    endtask

    task automatic test_flush();
        drive(1, 9'h0D3, 8'h50, 0, 0, 0);
        tick();
        drive(1, 9'h0E7, 8'h51, 0, 1, 0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b want 0", out_valid); end
        drive(0, '0, '0, 1, 0, 0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
        drive(1, 9'b111_11_0101, 8'h52, 0, 0, 0);
        tick();
        drive(0, '0, '0, 0, 1, 0);
        tick();
        drive(1, 9'h0C0, 8'h53, 1, 0, 0);
        #1;
        checks++; if (halted !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_pend: halted %b valid %b ready %b want 0 0 1", halted, out_valid, in_ready); end
        tick();
    endtask

    task automatic test_illegal_sat();
        for (int i = 0; i < 20; i++) begin
            drive(1, {3'b110, 2'b11, 4'($urandom)}, 8'(i), 1, 0, 0);
            tick();
            checks++; if (out_illegal !== 1'b1 || out_reg_we !== 1'b0 || out_mem_rd !== 1'b0 || out_mem_wr !== 1'b0 || out_branch !== 1'b0)
                begin errors++; $display("FAIL ill_flags%0d: ill %b we %b want 1 0", i, out_illegal, out_reg_we); end
            checks++; if (int'(ill_count) !== m_cnt) begin errors++; $display("FAIL ill_count%0d: got %0d want %0d", i, ill_count, m_cnt); end
        end
        checks++; if (ill_count !== 4'd15) begin errors++; $display("FAIL ill_saturate: got %0d want 15", ill_count); end
        drive(0, '0, '0, 1, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] w;
        for (int i = 0; i < 8; i++) begin
            w = 9'($urandom);
            if (w[8:4] == 5'b11111) w[4] = 1'b0;
            drive(1, w, 8'(8'h80 + i), 1, 0, 0);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 8'(8'h80 + i) || dut_out() !== m_out)
                begin errors++; $display("FAIL b2b_out%0d: valid %b got %h want %h", i, out_valid, dut_out(), m_out); end
            if (i == 4) begin
                #2 rst_n = 1'b0;
                #1;
                checks++; if (out_valid !== 1'b0 || ill_count !== '0)
                    begin errors++; $display("FAIL b2b_reset: valid %b cnt %0d want 0 0", out_valid, ill_count); end
                model_reset();
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end
        drive(0, '0, '0, 1, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), 9'($urandom), 8'($urandom), ($urandom_range(9) < 7),
                  ($urandom_range(15) == 0), ($urandom_range(7) == 0));
            #1;
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", i, in_ready, exp_ready()); end
            tick();
            checks++; if (out_valid !== m_valid || halted !== (m_mode == 2) || int'(ill_count) !== m_cnt)
                begin errors++; $display("FAIL rnd_status%0d: v %b h %b c %0d want %b %b %0d", i, out_valid, halted, ill_count, m_valid, (m_mode == 2), m_cnt); end
            if (m_valid) begin
                checks++; if (dut_out() !== m_out) begin errors++; $display("FAIL rnd_fields%0d: got %h want %h", i, dut_out(), m_out); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_branch_stall();
        test_halt();
        test_flush();
        test_illegal_sat();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
